vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/raster timing generator; successor to the fixed 640x480 sync generator.
//  Produces H/V sync, display-enable, pixel coordinates and line/frame strobes from programmable
//  porch/sync/active lengths, with sync polarity per axis.
//  Sits between the pixel clock domain root and the pixel pipeline (renderers, framebuffer readout).
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  H_POL     0    hsync asserted level (0 = active-low)
//  V_POL     0    vsync asserted level (0 = active-low)
//  CW        12   coordinate/counter width
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  pix_ce       in   1   pixel clock-enable (only with VGA_TIMING_PIX_CE_EN)
//  hsync        out  1   horizontal sync, polarity H_POL
//  vsync        out  1   vertical sync, polarity V_POL
//  de           out  1   display enable, high when x<H_ACTIVE && y<V_ACTIVE
//  x            out  CW  current horizontal position, 0..H_TOTAL-1
//  y            out  CW  current vertical position, 0..V_TOTAL-1
//  line_start   out  1   one-cycle strobe when x becomes 0
//  frame_start  out  1   one-cycle strobe when (x,y) becomes (0,0)
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default).
//  - Elaboration error if any timing param is 0 or H_TOTAL/V_TOTAL > 2**CW.
//  - All outputs registered and mutually aligned: in the cycle x==X,y==Y every output reflects (X,Y).
//  - Reset (async assert, sync release): x=H_TOTAL-1, y=V_TOTAL-1, de=0, hsync=~H_POL,
//    vsync=~V_POL, strobes=0. Reset mid-frame abandons the frame immediately.
//  - First advancing edge after release moves to (0,0): de=1, line_start=1, frame_start=1.
//  - Advance: x wraps H_TOTAL-1 -> 0 and y increments; y wraps V_TOTAL-1 -> 0 on the same edge.
//  - hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
//  - vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; changes only with x==0.
//  - Per-axis phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE, driven by the axis counter
//    reaching each phase boundary; de/sync decoded from phase, not from wide comparators.
//  - Strobes high for exactly one clk after the advancing edge, then low.
// CONFIGURATION
//  VGA_TIMING_PIX_CE_EN defined: pix_ce port exists; counters/outputs advance only on edges
//    with pix_ce=1, otherwise hold; strobes still last one clk only.
//  Undefined: no pix_ce port; advance on every clk edge.
// STRUCTURE
//  vga_timing_pkg: phase enum (PH_ACTIVE, PH_FP, PH_SYNC, PH_BP), 640x480@60 default constants.
//  Sub-module vga_axis_counter (params ACTIVE/FP/SYNC/BP/CW): counter, phase FSM, wrap flag;
//    instantiated for H (step every advance) and V (step on H wrap).
// TESTING
//  1 Reset then run 800*525 clks -> exactly 1 frame_start, 525 line_start, 307200 de cycles.
//  2 Defaults -> hsync low for x=656..751 only; vsync low for y=490..491, edges at x==0.
//  3 H_POL=1,V_POL=1, H_ACTIVE=8,H_FP=H_SYNC=H_BP=2 -> hsync high x=10..11, period 14.
//  4 Assert rst_n=0 at (300,200) -> outputs reset same cycle, async; after release (0,0) w/ strobes.
//  5 PIX_CE_EN, pix_ce=1 one cycle in 3 -> frame length 3*420000 clks, strobes 1 clk wide.
//  6 Wrap (799,524)->(0,0): y and x wrap on same edge, frame_start and line_start both 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing for the raster timing generator.
// Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 12;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE->FP->SYNC->BP phase FSM.
// Exposes the next-state phase so the top can register decoded outputs in step with the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_step,
  output logic [CW-1:0] o_cnt,
  output phase_t        o_phase_nxt,
  output logic          o_wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 ||
      64'(TOTAL) > (64'd1 << CW)) begin : g_param_check
    $error("vga_axis_counter: zero timing length or total exceeds counter range");
  end

  localparam logic [CW-1:0] L_LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] L_ACT_END  = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] L_FP_END   = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] L_SYNC_END = CW'(ACTIVE + FP + SYNC - 1);

  logic [CW-1:0] r_cnt;
  phase_t        r_phase;
  logic [CW-1:0] w_cnt_nxt;
  phase_t        w_phase_nxt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == L_LAST);

  // Phase changes on the step that carries the counter onto a boundary, so
  // phase and count always describe the same position.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (i_step) begin
      if (w_wrap) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = PH_ACTIVE;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        unique case (r_phase)
          PH_ACTIVE: if (r_cnt == L_ACT_END)  w_phase_nxt = PH_FP;
          PH_FP:     if (r_cnt == L_FP_END)   w_phase_nxt = PH_SYNC;
          PH_SYNC:   if (r_cnt == L_SYNC_END) w_phase_nxt = PH_BP;
          default:   w_phase_nxt = r_phase;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= L_LAST;
      r_phase <= PH_BP;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_phase_nxt = w_phase_nxt;
  assign o_wrap      = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: sync, display enable, coordinates and strobes.
// Optional macro VGA_TIMING_PIX_CE_EN adds a pix_ce input that gates every advance.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef VGA_TIMING_PIX_CE_EN
  input  logic          pix_ce,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic   w_adv;
  logic   w_h_wrap;
  logic   w_v_wrap;
  phase_t w_h_phase_nxt;
  phase_t w_v_phase_nxt;

`ifdef VGA_TIMING_PIX_CE_EN
  assign w_adv = pix_ce;
`else
  assign w_adv = 1'b1;
`endif

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_step     (w_adv),
    .o_cnt      (x),
    .o_phase_nxt(w_h_phase_nxt),
    .o_wrap     (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_step     (w_adv & w_h_wrap),
    .o_cnt      (y),
    .o_phase_nxt(w_v_phase_nxt),
    .o_wrap     (w_v_wrap)
  );

  logic r_hsync;
  logic r_vsync;
  logic r_de;
  logic r_line_start;
  logic r_frame_start;

  // Decode from next-state phases so these registers land on the same edge as x/y.
  // The release of rst_n is expected to arrive already synchronised to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (w_h_phase_nxt == PH_SYNC) ? H_POL : ~H_POL;
      r_vsync       <= (w_v_phase_nxt == PH_SYNC) ? V_POL : ~V_POL;
      r_de          <= (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
      r_line_start  <= w_adv & w_h_wrap;
      r_frame_start <= w_adv & w_h_wrap & w_v_wrap;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance checked from a vector table,
// plus a tiny 14x8 instance (positive syncs) checked every cycle against a reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef VGA_TIMING_PIX_CE_EN
  logic pix_ce = 1'b1;
`endif

  always #5 clk = ~clk;

  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [11:0] b_x, b_y;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [5:0]  s_x, s_y;

  vga_timing_gen u_big (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef VGA_TIMING_PIX_CE_EN
    .pix_ce     (pix_ce),
`endif
    .hsync      (b_hs),
    .vsync      (b_vs),
    .de         (b_de),
    .x          (b_x),
    .y          (b_y),
    .line_start (b_ls),
    .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(6)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef VGA_TIMING_PIX_CE_EN
    .pix_ce     (pix_ce),
`endif
    .hsync      (s_hs),
    .vsync      (s_vs),
    .de         (s_de),
    .x          (s_x),
    .y          (s_y),
    .line_start (s_ls),
    .frame_start(s_fs)
  );

  typedef struct {
    int n;
    int x;
    int y;
    int de;
    int hs;
    int vs;
    int ls;
    int fs;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;
  int n, ti, ls_cnt, fs_cnt, hs_low;
  int s_ls_cnt, s_fs_cnt, s_de_cnt, adv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference for the 14x8 instance: position k advances since release.
  task automatic check_small(input int k, input bit adv);
    int mx, my;
    mx = k % 14;
    my = (k / 14) % 8;
    chk($sformatf("s_x@%0d", k), 32'(s_x), mx);
    chk($sformatf("s_y@%0d", k), 32'(s_y), my);
    chk($sformatf("s_hs@%0d", k), 32'(s_hs), 32'(mx >= 10 && mx < 12));
    chk($sformatf("s_vs@%0d", k), 32'(s_vs), 32'(my >= 5 && my < 7));
    chk($sformatf("s_de@%0d", k), 32'(s_de), 32'(mx < 8 && my < 4));
    chk($sformatf("s_ls@%0d", k), 32'(s_ls), 32'(adv && mx == 0));
    chk($sformatf("s_fs@%0d", k), 32'(s_fs), 32'(adv && mx == 0 && my == 0));
  endtask

  task automatic check_big_reset(input string tag);
    chk({tag, "_x"},  32'(b_x), 799);
    chk({tag, "_y"},  32'(b_y), 524);
    chk({tag, "_de"}, 32'(b_de), 0);
    chk({tag, "_hs"}, 32'(b_hs), 1);
    chk({tag, "_vs"}, 32'(b_vs), 1);
    chk({tag, "_ls"}, 32'(b_ls), 0);
    chk({tag, "_fs"}, 32'(b_fs), 0);
    chk({tag, "_sx"}, 32'(s_x), 13);
    chk({tag, "_sy"}, 32'(s_y), 7);
    chk({tag, "_shs"}, 32'(s_hs), 0);
    chk({tag, "_svs"}, 32'(s_vs), 0);
    chk({tag, "_sde"}, 32'(s_de), 0);
  endtask

  initial begin
    //             n     x    y  de hs vs ls fs
    tbl[0]  = '{   1,    0,   0, 1, 1, 1, 1, 1};
    tbl[1]  = '{   2,    1,   0, 1, 1, 1, 0, 0};
    tbl[2]  = '{ 640,  639,   0, 1, 1, 1, 0, 0};
    tbl[3]  = '{ 641,  640,   0, 0, 1, 1, 0, 0};
    tbl[4]  = '{ 656,  655,   0, 0, 1, 1, 0, 0};
    tbl[5]  = '{ 657,  656,   0, 0, 0, 1, 0, 0};
    tbl[6]  = '{ 752,  751,   0, 0, 0, 1, 0, 0};
    tbl[7]  = '{ 753,  752,   0, 0, 1, 1, 0, 0};
    tbl[8]  = '{ 800,  799,   0, 0, 1, 1, 0, 0};
    tbl[9]  = '{ 801,    0,   1, 1, 1, 1, 1, 0};
    tbl[10] = '{1601,    0,   2, 1, 1, 1, 1, 0};
    tbl[11] = '{1900,  299,   2, 1, 1, 1, 0, 0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_big_reset("rst");

    rst_n = 1'b1;
    n = 0; ti = 0; ls_cnt = 0; fs_cnt = 0; hs_low = 0;
    while (n < 1901) begin
      tick();
      n++;
      check_small(n - 1, 1'b1);
      if (b_ls) ls_cnt++;
      if (b_fs) fs_cnt++;
      if (n <= 800 && !b_hs) hs_low++;
      if (ti < NV && tbl[ti].n == n) begin
        chk($sformatf("x@%0d", n),  32'(b_x),  tbl[ti].x);
        chk($sformatf("y@%0d", n),  32'(b_y),  tbl[ti].y);
        chk($sformatf("de@%0d", n), 32'(b_de), tbl[ti].de);
        chk($sformatf("hs@%0d", n), 32'(b_hs), tbl[ti].hs);
        chk($sformatf("vs@%0d", n), 32'(b_vs), tbl[ti].vs);
        chk($sformatf("ls@%0d", n), 32'(b_ls), tbl[ti].ls);
        chk($sformatf("fs@%0d", n), 32'(b_fs), tbl[ti].fs);
        ti++;
      end
    end
    chk("table_reached", ti, NV);
    chk("line_starts", ls_cnt, 3);
    chk("frame_starts", fs_cnt, 1);
    chk("hsync_low_cycles", hs_low, 96);
    chk("mid_x", 32'(b_x), 300);
    chk("mid_y", 32'(b_y), 2);

    // Mid-frame reset: outputs must drop before the next clock edge.
    rst_n = 1'b0;
    #1;
    check_big_reset("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    s_ls_cnt = 0; s_fs_cnt = 0; s_de_cnt = 0;
    for (int k = 0; k < 224; k++) begin
      tick();
      check_small(k, 1'b1);
      if (s_ls) s_ls_cnt++;
      if (s_fs) s_fs_cnt++;
      if (s_de) s_de_cnt++;
      if (k == 0) begin
        chk("rel_x", 32'(b_x), 0);
        chk("rel_y", 32'(b_y), 0);
        chk("rel_de", 32'(b_de), 1);
        chk("rel_ls", 32'(b_ls), 1);
        chk("rel_fs", 32'(b_fs), 1);
      end else if (k == 1) begin
        chk("rel1_x", 32'(b_x), 1);
        chk("rel1_ls", 32'(b_ls), 0);
        chk("rel1_fs", 32'(b_fs), 0);
      end
    end
    chk("s_frame_starts", s_fs_cnt, 2);
    chk("s_line_starts", s_ls_cnt, 16);
    chk("s_de_cycles", s_de_cnt, 64);

`ifdef VGA_TIMING_PIX_CE_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s_ls_cnt = 0; s_fs_cnt = 0; adv_cnt = 0;
    for (int i = 0; i < 336; i++) begin
      pix_ce = (i % 3 == 0);
      tick();
      if (pix_ce) adv_cnt++;
      check_small(adv_cnt - 1, pix_ce);
      if (s_ls) s_ls_cnt++;
      if (s_fs) s_fs_cnt++;
    end
    pix_ce = 1'b1;
    chk("ce_frame_starts", s_fs_cnt, 1);
    chk("ce_line_starts", s_ls_cnt, 8);
    chk("ce_end_x", 32'(s_x), 13);
    chk("ce_end_y", 32'(s_y), 7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
